param_updown_counter: RTL and testbench
=======================================

PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter width in bits, legal range 2..32.
REQ-002 SHALL have parameter RST_VAL, default 0: value loaded into q on reset; if greater than 2**WIDTH-1, elaboration SHALL fail.
REQ-003 SHALL have port clk  in  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1: reset, synchronous, active-low (rst=0 resets on the next rising clk).
REQ-005 SHALL have port en  in  1: count enable.
REQ-006 SHALL have port up  in  1: direction; 1 = count up, 0 = count down.
REQ-007 SHALL have port sat  in  1: terminal mode; 0 = wrap, 1 = saturate.
REQ-008 SHALL have port load  in  1: synchronous parallel load strobe.
REQ-009 SHALL have port load_val  in  WIDTH: value for a parallel load.
REQ-010 SHALL have port max_val  in  WIDTH: runtime modulus top; the count range is 0..max_val.
REQ-011 SHALL have port q  out  WIDTH: registered count.
REQ-012 SHALL have port tc  out  1: terminal-count indication, combinational from registered state and inputs.
REQ-013 SHALL have port ovf  out  1: sticky wrap/saturation flag, registered.

Function
REQ-014 Per-edge priority SHALL be: reset > load > count (en=1) > hold.
REQ-015 Load SHALL set q to min(load_val, max_val) and clear ovf, regardless of en.
REQ-016 Counting up with q < max_val SHALL set q to q+1.
REQ-017 Counting up with q >= max_val SHALL set q to 0 when sat=0, or to max_val when sat=1; ovf SHALL be set in both cases.
REQ-018 Counting down with 0 < q <= max_val SHALL set q to q-1.
REQ-019 Counting down with q > max_val (max_val lowered at runtime) SHALL set q to max_val without setting ovf.
REQ-020 Counting down with q == 0 SHALL set q to max_val when sat=0, or hold 0 when sat=1; ovf SHALL be set in both cases.
REQ-021 tc SHALL equal en & ~load & ((up & q>=max_val) | (~up & q==0)), so it is high exactly in the cycle before a terminal event.
REQ-022 With max_val == 0, q SHALL remain 0, and tc SHALL be high whenever en=1 and load=0.
REQ-023 A change on up or sat SHALL take effect on the same edge; no pipeline.
REQ-024 en=0 with load=0 SHALL hold q and ovf unchanged.
REQ-025 Latency SHALL be one clk from input sample to q/ovf update; tc has zero latency.

Reset
REQ-026 On rst=0 at a rising clk, q SHALL become RST_VAL and ovf SHALL become 0, overriding load and en.
REQ-027 Reset asserted mid-count SHALL discard any pending terminal event; tc SHALL be ignored while rst=0.
REQ-028 The first edge with rst=1 SHALL behave as a normal cycle per REQ-014.
REQ-029 q SHALL be RST_VAL even when RST_VAL > max_val; subsequent counting SHALL follow REQ-017/REQ-019.

Structure
REQ-030 Shared package counter_pkg SHALL hold direction constants CNT_UP=1/CNT_DOWN=0 and mode constants MODE_WRAP=0/MODE_SAT=1.
REQ-031 The block SHALL be a single module with one clocked process for q/ovf and one combinational next-state/tc block; no sub-module.
REQ-032 The block SHALL contain no derived or gated clocks; all flops SHALL be on clk, unlike ripple designs.

Verification (WIDTH=4, RST_VAL=0)
REQ-033 Wrap up: rst low 1 cycle, max_val=9, up=1, en=1, sat=0 for 12 cycles -> q 1..9, 0, 1, 2; tc high when q=9; ovf set after the 0 wrap.
REQ-034 Saturate down: load_val=3, load 1 cycle, then up=0, sat=1, en=1 for 5 cycles -> q 3, 2, 1, 0, 0, 0; ovf=1; tc high while q=0.
REQ-035 Load clamp and priority: max_val=5, load_val=12, load=1, en=1 -> q=5 and ovf cleared; rst=0 with load=1 -> q=0.
REQ-036 Runtime modulus shrink: q=8, max_val changed to 4, up=0 -> q=4 with ovf unchanged; then up=1 -> q=0 with ovf set.
REQ-037 Hold and zero modulus: en=0 for 3 cycles -> q and ovf stable; max_val=0, en=1 -> q stays 0 and tc stays high.
REQ-038 Full range: max_val=15, up=1, sat=0 -> q wraps 15 to 0 with no X on any output; self-checking model compare every cycle.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter: direction and terminal-mode encodings.
package counter_pkg;

  localparam logic CNT_UP    = 1'b1;
  localparam logic CNT_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage : counter_pkg

// File: rtl/param_updown_counter.sv
// Parameterised up/down counter with runtime modulus, wrap/saturate terminal mode,
// clamped parallel load and a sticky overflow flag.
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "param_updown_counter: WIDTH must be in 2..32");
  end

  if (64'(RST_VAL) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_rst_val
    $fatal(1, "param_updown_counter: RST_VAL does not fit in WIDTH bits");
  end

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic             at_top, at_zero;

  assign at_top  = (q_q >= max_val);
  assign at_zero = (q_q == '0);

  always_comb begin
    q_d   = q_q;
    ovf_d = ovf_q;
    if (load) begin
      q_d   = (load_val > max_val) ? max_val : load_val;
      ovf_d = 1'b0;
    end else if (en) begin
      if (up == CNT_UP) begin
        if (at_top) begin
          q_d   = (sat == MODE_SAT) ? max_val : '0;
          ovf_d = 1'b1;
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end else begin
        // A count left above a lowered modulus snaps back into range silently.
        if (q_q > max_val) begin
          q_d = max_val;
        end else if (at_zero) begin
          q_d   = (sat == MODE_SAT) ? '0 : max_val;
          ovf_d = 1'b1;
        end else begin
          q_d = q_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q   <= WIDTH'(RST_VAL);
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign tc  = en & ~load & (((up == CNT_UP) & at_top) | ((up == CNT_DOWN) & at_zero));
  assign q   = q_q;
  assign ovf = ovf_q;

endmodule : param_updown_counter

// File: tb/tb_param_updown_counter.sv
// Self-checking bench for param_updown_counter (WIDTH=4, RST_VAL=0): directed vector
// table with a q/ovf scoreboard, then a model-checked full-range and random phase.
module tb_param_updown_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, sat, load;
  logic [3:0] load_val, max_val, q;
  logic       tc, ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst, en, up, sat, load;
    logic [3:0] lv, mv;
    logic       chk_tc, tc;
    logic [3:0] q;
    logic       ovf;
  } vec_t;

  typedef struct {
    logic [3:0] q;
    logic       ovf;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  logic [3:0] mq;
  logic       movf;

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(4), .RST_VAL(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .sat      (sat),
    .load     (load),
    .load_val (load_val),
    .max_val  (max_val),
    .q        (q),
    .tc       (tc),
    .ovf      (ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, e, u, s, l, input logic [3:0] lv, mv,
                              input logic ct, t, input logic [3:0] eq, input logic eo);
    vec_t v;
    v.rst = r; v.en = e; v.up = u; v.sat = s; v.load = l; v.lv = lv; v.mv = mv;
    v.chk_tc = ct; v.tc = t; v.q = eq; v.ovf = eo;
    return v;
  endfunction

  // Drive one cycle: tc checked before the edge, q/ovf via scoreboard after it.
  task automatic step(input vec_t v, input string name);
    exp_t e;
    rst = v.rst; en = v.en; up = v.up; sat = v.sat; load = v.load;
    load_val = v.lv; max_val = v.mv;
    #1;
    if (v.chk_tc) chk({name, ".tc"}, {31'b0, tc}, {31'b0, v.tc});
    e.q = v.q; e.ovf = v.ovf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({name, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({name, ".q"}, {28'b0, q}, {28'b0, e.q});
      chk({name, ".ovf"}, {31'b0, ovf}, {31'b0, e.ovf});
    end
    chk({name, ".no_x"}, {31'b0, $isunknown({q, tc, ovf})}, 32'd0);
    mq = v.q; movf = v.ovf;
  endtask

  // Reference behaviour derived from the priority/terminal rules.
  function automatic vec_t model(input logic r, e, u, s, l, input logic [3:0] lv, mv,
                                 input logic [3:0] cq, input logic co);
    logic [3:0] nq;
    logic       no, t;
    t  = e & ~l & ((u & (cq >= mv)) | (~u & (cq == 4'd0)));
    nq = cq; no = co;
    if (!r) begin
      nq = 4'd0; no = 1'b0;
    end else if (l) begin
      nq = (lv > mv) ? mv : lv; no = 1'b0;
    end else if (e) begin
      if (u) begin
        if (cq >= mv) begin nq = s ? mv : 4'd0; no = 1'b1; end
        else nq = cq + 4'd1;
      end else begin
        if (cq > mv) nq = mv;
        else if (cq == 4'd0) begin nq = s ? 4'd0 : mv; no = 1'b1; end
        else nq = cq - 4'd1;
      end
    end
    return mk(r, e, u, s, l, lv, mv, r, t, nq, no);
  endfunction

  initial begin
    // Reset with en=0 so tc is defined even before q is.
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 9, 1, 0, 0, 0));
    // Wrap up, max 9.
    for (int i = 1; i <= 9; i++) vecs.push_back(mk(1, 1, 1, 0, 0, 0, 9, 1, 0, 4'(i), 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 9, 1, 1, 0, 1));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 9, 1, 0, 1, 1));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 9, 1, 0, 2, 1));
    // Load 3 then saturate down.
    vecs.push_back(mk(1, 0, 1, 0, 1, 3, 9, 1, 0, 3, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 9, 1, 0, 2, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 9, 1, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 9, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 9, 1, 1, 0, 1));
    vecs.push_back(mk(1, 1, 0, 1, 0, 0, 9, 1, 1, 0, 1));
    // Load clamp with en=1, then reset beats load.
    vecs.push_back(mk(1, 1, 0, 1, 1, 12, 5, 1, 0, 5, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 12, 5, 1, 0, 0, 0));
    // Modulus shrink: 8 with max 4 counting down snaps to 4, ovf untouched.
    vecs.push_back(mk(1, 0, 1, 0, 1, 8, 15, 1, 0, 8, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 4, 1, 0, 4, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 4, 1, 1, 0, 1));
    // Hold.
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 1, 0, 0, 0, 4, 1, 0, 0, 1));
    // Zero modulus, both directions and a clamped load.
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 1, 1, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1));
    vecs.push_back(mk(1, 1, 1, 0, 1, 7, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0, 1, 1, 0, 1));
    // Down-wrap from 0 to max, then reset overrides a pending terminal event.
    vecs.push_back(mk(1, 0, 1, 0, 1, 0, 6, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 6, 1, 1, 6, 1));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 6, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 6, 1, 0, 1, 0));

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("vec%0d", i));

    // Full-range wrap 15 -> 0 with model compare every cycle.
    for (int i = 0; i < 20; i++)
      step(model(1, 1, 1, 0, 0, 0, 15, mq, movf), $sformatf("full%0d", i));

    // Random mix, reset included.
    for (int i = 0; i < 60; i++) begin
      logic r, e, u, s, l;
      logic [3:0] lv, mv;
      r  = ($urandom_range(0, 15) != 0);
      e  = ($urandom_range(0, 3) != 0);
      u  = 1'($urandom);
      s  = 1'($urandom);
      l  = ($urandom_range(0, 7) == 0);
      lv = 4'($urandom);
      mv = 4'($urandom);
      step(model(r, e, u, s, l, lv, mv, mq, movf), $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_param_updown_counter
